// File: rtl/pll_rstseq_pkg.sv
// pll_rstseq_pkg
//   Shared definitions for the PLL reset sequencer: the sequencer state
//   encoding, default parameter values and the counter width helper.
//   Optional lock timeout is selected with PLL_RSTSEQ_LOCK_TIMEOUT_EN
//   (see pll_reset_sequencer).
package pll_rstseq_pkg;

  typedef enum logic [1:0] {
    PLL_RST   = 2'd0,
    WAIT_LOCK = 2'd1,
    RELEASE   = 2'd2,
    RUN       = 2'd3
  } pll_rstseq_state_e;

  localparam int unsigned LP_DEF_PLL_RST_CYCLES      = 16;
  localparam int unsigned LP_DEF_LOCK_STABLE_CYCLES  = 1024;
  localparam int unsigned LP_DEF_LOCK_TIMEOUT_CYCLES = 65536;
  localparam int unsigned LP_DEF_STAGE_GAP_CYCLES    = 8;
  localparam int unsigned LP_DEF_DOMAINS             = 4;
  localparam int unsigned LP_RETRY_W                 = 8;

  // Bits needed to hold the values 0..max_val (never less than 1).
  function automatic int unsigned cnt_width(input int unsigned max_val);
    int unsigned w;
    w = $clog2(max_val + 1);
    return (w == 0) ? 1 : w;
  endfunction

endpackage

// File: rtl/pll_rstseq_if.sv
// pll_rstseq_if
//   Control/status bundle of the PLL reset sequencer.
//   iRELOCK_REQ     level re-lock request (to sequencer)
//   oPLL_RESET      PLL rst, active-high
//   oRELOCK_ACK     one-cycle pulse when a re-lock request is accepted
//   onDOMAIN_RESET  per-domain reset, active-low, released 0..P_DOMAINS-1
//   oREADY          high while every domain is released
//   oLOCK_LOST      one-cycle pulse on lock loss after release began
//   oRETRY_COUNT    lock-timeout retries, saturating
//   Modports: master = requester/observer, slave = sequencer.
interface pll_rstseq_if
  import pll_rstseq_pkg::*;
#(
  parameter int unsigned P_DOMAINS = LP_DEF_DOMAINS
);

  logic                  iRELOCK_REQ;
  logic                  oPLL_RESET;
  logic                  oRELOCK_ACK;
  logic [P_DOMAINS-1:0]  onDOMAIN_RESET;
  logic                  oREADY;
  logic                  oLOCK_LOST;
  logic [LP_RETRY_W-1:0] oRETRY_COUNT;

  modport master (
    output iRELOCK_REQ,
    input  oPLL_RESET,
    input  oRELOCK_ACK,
    input  onDOMAIN_RESET,
    input  oREADY,
    input  oLOCK_LOST,
    input  oRETRY_COUNT
  );

  modport slave (
    input  iRELOCK_REQ,
    output oPLL_RESET,
    output oRELOCK_ACK,
    output onDOMAIN_RESET,
    output oREADY,
    output oLOCK_LOST,
    output oRETRY_COUNT
  );

endinterface

// File: rtl/pll_locked_sync.sv
// pll_locked_sync
//   Two-flop synchronizer bringing the PLL locked flag into the reference
//   clock domain. Both flops reset asynchronously to 0.
//   clk_i   reference clock
//   rst_ni  asynchronous active-low reset
//   d_i     asynchronous input
//   q_o     synchronized output
module pll_locked_sync (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer
//   Holds the PLL in reset, waits for a debounced lock, then releases the
//   per-domain resets in order 0..P_DOMAINS-1 with P_STAGE_GAP_CYCLES between
//   releases. Lock loss in RELEASE/RUN, or an accepted re-lock request in RUN,
//   re-asserts every domain reset at once and restarts from PLL_RST.
//   iCLOCK       reference clock, the only clock
//   inRESET      asynchronous active-low reset
//   iPLL_LOCKED  PLL locked, asynchronous to iCLOCK
//   bus          pll_rstseq_if.slave (re-lock request, PLL reset, domain
//                resets, ready/ack/lock-lost pulses, retry count)
//   Macro PLL_RSTSEQ_LOCK_TIMEOUT_EN: when defined, WAIT_LOCK gives up after
//   P_LOCK_TIMEOUT_CYCLES, returns to PLL_RST and counts a retry; otherwise
//   WAIT_LOCK waits indefinitely and oRETRY_COUNT is 0.
module pll_reset_sequencer
  import pll_rstseq_pkg::*;
#(
  parameter int unsigned P_PLL_RST_CYCLES      = LP_DEF_PLL_RST_CYCLES,
  parameter int unsigned P_LOCK_STABLE_CYCLES  = LP_DEF_LOCK_STABLE_CYCLES,
  parameter int unsigned P_LOCK_TIMEOUT_CYCLES = LP_DEF_LOCK_TIMEOUT_CYCLES,
  parameter int unsigned P_STAGE_GAP_CYCLES    = LP_DEF_STAGE_GAP_CYCLES,
  parameter int unsigned P_DOMAINS             = LP_DEF_DOMAINS
)(
  input  logic             iCLOCK,
  input  logic             inRESET,
  input  logic             iPLL_LOCKED,
  pll_rstseq_if.slave      bus
);

  localparam int unsigned RW = cnt_width(P_PLL_RST_CYCLES);
  localparam int unsigned SW = cnt_width(P_LOCK_STABLE_CYCLES);
  localparam int unsigned GW = cnt_width(P_STAGE_GAP_CYCLES);

  localparam logic [RW-1:0]        LP_RST_LAST       = RW'(P_PLL_RST_CYCLES - 1);
  localparam logic [SW-1:0]        LP_STABLE_REACHED = SW'(P_LOCK_STABLE_CYCLES);
  localparam logic [GW-1:0]        LP_GAP_LAST       = GW'(P_STAGE_GAP_CYCLES - 1);
  localparam logic [P_DOMAINS-1:0] LP_DOM_FIRST      = P_DOMAINS'(1);

  pll_rstseq_state_e     state_q;
  logic [RW-1:0]         rst_cnt_q;
  logic [SW-1:0]         stable_q;
  logic [GW-1:0]         gap_q;
  logic [P_DOMAINS-1:0]  dom_q;
  logic                  pll_rst_q;
  logic                  ready_q;
  logic                  ack_q;
  logic                  lost_q;

  logic                  lk;
  logic                  lose_lock;
  logic                  relock;
  logic [P_DOMAINS-1:0]  dom_next;

`ifdef PLL_RSTSEQ_LOCK_TIMEOUT_EN
  localparam int unsigned TW = cnt_width(P_LOCK_TIMEOUT_CYCLES);
  localparam logic [TW-1:0] LP_TIMEOUT_LAST = TW'(P_LOCK_TIMEOUT_CYCLES - 1);

  logic [TW-1:0]         to_q;
  logic [LP_RETRY_W-1:0] retry_q;
`endif

  pll_locked_sync u_lock_sync (
    .clk_i  (iCLOCK),
    .rst_ni (inRESET),
    .d_i    (iPLL_LOCKED),
    .q_o    (lk)
  );

  // Domain resets form a thermometer code: each release shifts in one more
  // released bit, so out-of-order release is impossible by construction.
  always_comb begin
    dom_next = (dom_q << 1) | LP_DOM_FIRST;
  end

  // Lock loss has priority over a simultaneous re-lock request.
  always_comb begin
    lose_lock = 1'b0;
    relock    = 1'b0;
    if (state_q == RELEASE || state_q == RUN) begin
      lose_lock = !lk;
    end
    if (state_q == RUN) begin
      relock = lk && bus.iRELOCK_REQ;
    end
  end

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      state_q   <= PLL_RST;
      rst_cnt_q <= '0;
      stable_q  <= '0;
      gap_q     <= '0;
      dom_q     <= '0;
      pll_rst_q <= 1'b1;
      ready_q   <= 1'b0;
      ack_q     <= 1'b0;
      lost_q    <= 1'b0;
`ifdef PLL_RSTSEQ_LOCK_TIMEOUT_EN
      to_q      <= '0;
      retry_q   <= '0;
`endif
    end else begin
      ack_q  <= 1'b0;
      lost_q <= 1'b0;
      if (lose_lock || relock) begin
        state_q   <= PLL_RST;
        rst_cnt_q <= '0;
        stable_q  <= '0;
        gap_q     <= '0;
        dom_q     <= '0;
        pll_rst_q <= 1'b1;
        ready_q   <= 1'b0;
        lost_q    <= lose_lock;
        ack_q     <= relock;
      end else begin
        case (state_q)
          PLL_RST: begin
            stable_q <= '0;
            if (rst_cnt_q == LP_RST_LAST) begin
              rst_cnt_q <= '0;
              pll_rst_q <= 1'b0;
              state_q   <= WAIT_LOCK;
`ifdef PLL_RSTSEQ_LOCK_TIMEOUT_EN
              to_q      <= '0;
`endif
            end else begin
              rst_cnt_q <= rst_cnt_q + 1'b1;
            end
          end

          WAIT_LOCK: begin
            if (stable_q == LP_STABLE_REACHED) begin
              stable_q <= '0;
              gap_q    <= '0;
              dom_q    <= LP_DOM_FIRST;
              if (&LP_DOM_FIRST) begin
                ready_q <= 1'b1;
                state_q <= RUN;
              end else begin
                state_q <= RELEASE;
              end
            end
`ifdef PLL_RSTSEQ_LOCK_TIMEOUT_EN
            else if (to_q == LP_TIMEOUT_LAST) begin
              to_q      <= '0;
              stable_q  <= '0;
              pll_rst_q <= 1'b1;
              state_q   <= PLL_RST;
              if (retry_q != '1) begin
                retry_q <= retry_q + 1'b1;
              end
            end
`endif
            else begin
              stable_q <= lk ? stable_q + 1'b1 : '0;
`ifdef PLL_RSTSEQ_LOCK_TIMEOUT_EN
              to_q     <= to_q + 1'b1;
`endif
            end
          end

          RELEASE: begin
            if (gap_q == LP_GAP_LAST) begin
              gap_q <= '0;
              dom_q <= dom_next;
              if (&dom_next) begin
                ready_q <= 1'b1;
                state_q <= RUN;
              end
            end else begin
              gap_q <= gap_q + 1'b1;
            end
          end

          RUN: begin
            ready_q <= 1'b1;
          end

          default: begin
            state_q   <= PLL_RST;
            pll_rst_q <= 1'b1;
            dom_q     <= '0;
            ready_q   <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.oPLL_RESET     = pll_rst_q;
  assign bus.oRELOCK_ACK    = ack_q;
  assign bus.onDOMAIN_RESET = dom_q;
  assign bus.oREADY         = ready_q;
  assign bus.oLOCK_LOST     = lost_q;

`ifdef PLL_RSTSEQ_LOCK_TIMEOUT_EN
  assign bus.oRETRY_COUNT   = retry_q;
`else
  logic unused_timeout;
  assign unused_timeout     = (P_LOCK_TIMEOUT_CYCLES == 0);
  assign bus.oRETRY_COUNT   = '0;
`endif

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// tb_pll_reset_sequencer
//   Self-checking bench for pll_reset_sequencer with PLL_RST=4, STABLE=8,
//   TIMEOUT=64, GAP=2, DOMAINS=4. Per-cycle expected output words are queued
//   from the timing rules, then popped and compared one clock at a time.
//   Honours PLL_RSTSEQ_LOCK_TIMEOUT_EN for the retry scenario.
module tb_pll_reset_sequencer;

  localparam int unsigned P_RST = 4;
  localparam int unsigned P_STB = 8;
  localparam int unsigned P_TO  = 64;
  localparam int unsigned P_GAP = 2;
  localparam int unsigned P_DOM = 4;

  typedef struct packed {
    logic       pll;
    logic [3:0] dom;
    logic       rdy;
    logic       ack;
    logic       lost;
    logic [7:0] retry;
  } obs_t;

  logic clk    = 1'b0;
  logic rst_n  = 1'b0;
  logic locked = 1'b0;

  int   n_tests = 0;
  int   n_fail  = 0;
  obs_t exp_q[$];

  always #5 clk = ~clk;

  pll_rstseq_if #(.P_DOMAINS(P_DOM)) bus ();

  pll_reset_sequencer #(
    .P_PLL_RST_CYCLES      (P_RST),
    .P_LOCK_STABLE_CYCLES  (P_STB),
    .P_LOCK_TIMEOUT_CYCLES (P_TO),
    .P_STAGE_GAP_CYCLES    (P_GAP),
    .P_DOMAINS             (P_DOM)
  ) dut (
    .iCLOCK      (clk),
    .inRESET     (rst_n),
    .iPLL_LOCKED (locked),
    .bus         (bus)
  );

  function automatic obs_t mk(logic pll, logic [3:0] dom, logic rdy,
                              logic ack, logic lost, logic [7:0] retry);
    obs_t o;
    o.pll = pll; o.dom = dom; o.rdy = rdy; o.ack = ack; o.lost = lost; o.retry = retry;
    return o;
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o.pll   = bus.oPLL_RESET;
    o.dom   = bus.onDOMAIN_RESET;
    o.rdy   = bus.oREADY;
    o.ack   = bus.oRELOCK_ACK;
    o.lost  = bus.oLOCK_LOST;
    o.retry = bus.oRETRY_COUNT;
    return o;
  endfunction

  task automatic push_n(input int unsigned n, input obs_t v);
    repeat (n) exp_q.push_back(v);
  endtask

  // PLL reset held, nothing released.
  task automatic push_rst(input int unsigned n);
    push_n(n, mk(1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 8'd0));
  endtask

  task automatic push_idle(input int unsigned n);
    push_n(n, mk(1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 8'd0));
  endtask

  // Domains 0,1,2 at gap 2; caller pushes the final (ready) stage.
  task automatic push_staged();
    push_n(2, mk(1'b0, 4'b0001, 1'b0, 1'b0, 1'b0, 8'd0));
    push_n(2, mk(1'b0, 4'b0011, 1'b0, 1'b0, 1'b0, 8'd0));
    push_n(2, mk(1'b0, 4'b0111, 1'b0, 1'b0, 1'b0, 8'd0));
  endtask

  task automatic push_ready(input int unsigned n);
    push_n(n, mk(1'b0, 4'b1111, 1'b1, 1'b0, 1'b0, 8'd0));
  endtask

  // Holds reset for a few edges; returns #1 after the edge where it released.
  task automatic do_reset();
    rst_n = 1'b0;
    locked = 1'b0;
    bus.iRELOCK_REQ = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    obs_t got;
    obs_t want;
    rst_n = 1'b0;
    bus.iRELOCK_REQ = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    got = sample();
    want = mk(1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 8'd0);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL reset_values got=%h want=%h", got, want);
    end
  endtask

  // Locked rises after tick 10: domain 0 at tick 21, ready with domain 3 at 27.
  task automatic test_powerup();
    obs_t got;
    obs_t want;
    do_reset();
    push_rst(3);
    push_idle(17);
    push_staged();
    push_ready(4);
    for (int unsigned k = 1; exp_q.size() != 0; k++) begin
      @(posedge clk); #1;
      got = sample();
      want = exp_q.pop_front();
      n_tests++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL powerup t=%0d got=%h want=%h", k, got, want);
      end
      if (k == 10) locked = 1'b1;
    end
  endtask

  // Shape shared by the lock-loss scenarios, starting from RUN.
  task automatic push_loss_reseq();
    push_ready(2);
    push_n(1, mk(1'b1, 4'b0000, 1'b0, 1'b0, 1'b1, 8'd0));
    push_rst(3);
    push_idle(14);
    push_staged();
    push_ready(4);
  endtask

  task automatic test_lock_loss();
    obs_t got;
    obs_t want;
    push_loss_reseq();
    locked = 1'b0;
    for (int unsigned k = 1; exp_q.size() != 0; k++) begin
      @(posedge clk); #1;
      got = sample();
      want = exp_q.pop_front();
      n_tests++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL lock_loss t=%0d got=%h want=%h", k, got, want);
      end
      if (k == 10) locked = 1'b1;
    end
  endtask

  // Request held 3 cycles in RUN, then a request during WAIT_LOCK.
  task automatic test_relock();
    obs_t got;
    obs_t want;
    push_n(1, mk(1'b1, 4'b0000, 1'b0, 1'b1, 1'b0, 8'd0));
    push_rst(3);
    push_idle(9);
    push_staged();
    push_ready(5);
    bus.iRELOCK_REQ = 1'b1;
    for (int unsigned k = 1; exp_q.size() != 0; k++) begin
      @(posedge clk); #1;
      got = sample();
      want = exp_q.pop_front();
      n_tests++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL relock t=%0d got=%h want=%h", k, got, want);
      end
      if (k == 3) bus.iRELOCK_REQ = 1'b0;
      if (k == 7) bus.iRELOCK_REQ = 1'b1;
      if (k == 9) bus.iRELOCK_REQ = 1'b0;
    end
  endtask

  // Request arrives on the same edge that sees lock loss: no ACK, LOCK_LOST only.
  task automatic test_loss_vs_req();
    obs_t got;
    obs_t want;
    push_loss_reseq();
    locked = 1'b0;
    for (int unsigned k = 1; exp_q.size() != 0; k++) begin
      @(posedge clk); #1;
      got = sample();
      want = exp_q.pop_front();
      n_tests++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL loss_vs_req t=%0d got=%h want=%h", k, got, want);
      end
      if (k == 2) bus.iRELOCK_REQ = 1'b1;
      if (k == 3) bus.iRELOCK_REQ = 1'b0;
      if (k == 10) locked = 1'b1;
    end
  endtask

  // Locked drops for one cycle out of every five: stable count never hits 8.
  task automatic test_glitch();
    obs_t got;
    obs_t want;
    do_reset();
    locked = 1'b1;
    push_rst(3);
    push_idle(57);
    for (int unsigned k = 1; exp_q.size() != 0; k++) begin
      @(posedge clk); #1;
      got = sample();
      want = exp_q.pop_front();
      n_tests++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL glitch t=%0d got=%h want=%h", k, got, want);
      end
      locked = ((k % 5) != 4);
    end
  endtask

  // Reset pulsed with two domains released; outputs must drop without an edge.
  task automatic test_async_reset();
    obs_t got;
    obs_t want;
    do_reset();
    locked = 1'b1;
    push_rst(3);
    push_idle(9);
    push_n(2, mk(1'b0, 4'b0001, 1'b0, 1'b0, 1'b0, 8'd0));
    push_n(2, mk(1'b0, 4'b0011, 1'b0, 1'b0, 1'b0, 8'd0));
    for (int unsigned k = 1; exp_q.size() != 0; k++) begin
      @(posedge clk); #1;
      got = sample();
      want = exp_q.pop_front();
      n_tests++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL async_pre t=%0d got=%h want=%h", k, got, want);
      end
    end
    want = mk(1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 8'd0);
    #3 rst_n = 1'b0;
    #1;
    got = sample();
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL async_assert got=%h want=%h", got, want);
    end
    repeat (2) @(posedge clk);
    #1;
    got = sample();
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL async_hold got=%h want=%h", got, want);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    push_rst(3);
    push_idle(9);
    push_staged();
    push_ready(7);
    for (int unsigned k = 1; exp_q.size() != 0; k++) begin
      @(posedge clk); #1;
      got = sample();
      want = exp_q.pop_front();
      n_tests++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL async_restart t=%0d got=%h want=%h", k, got, want);
      end
    end
  endtask

  task automatic test_timeout();
    obs_t got;
    obs_t want;
    int unsigned r;
    do_reset();
`ifdef PLL_RSTSEQ_LOCK_TIMEOUT_EN
    // Retry every 4+64 cycles; count saturates at 255.
    for (int unsigned k = 1; k <= 260 * 68; k++) begin
      r = k / 68;
      exp_q.push_back(mk(((k % 68) < 4), 4'b0000, 1'b0, 1'b0, 1'b0,
                         8'((r > 255) ? 255 : r)));
    end
`else
    r = 0;
    for (int unsigned k = 1; k <= 200; k++) begin
      exp_q.push_back(mk((k < 4), 4'b0000, 1'b0, 1'b0, 1'b0, 8'(r)));
    end
`endif
    for (int unsigned k = 1; exp_q.size() != 0; k++) begin
      @(posedge clk); #1;
      got = sample();
      want = exp_q.pop_front();
      n_tests++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL timeout t=%0d got=%h want=%h", k, got, want);
      end
    end
  endtask

  initial begin
    bus.iRELOCK_REQ = 1'b0;
    test_reset();
    test_powerup();
    test_lock_loss();
    test_relock();
    test_loss_vs_req();
    test_glitch();
    test_async_reset();
    test_timeout();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "time limit reached");
  end

endmodule
